// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the alarm ring controller and its neighbours
// (timegen ticks, time/alarm digits, button pulses, fsm load strobes).
interface alarm_ring_ctrl_if;
  logic       one_second;
  logic       one_minute;
  logic [3:0] current_time_ms_hr;
  logic [3:0] current_time_ls_hr;
  logic [3:0] current_time_ms_min;
  logic [3:0] current_time_ls_min;
  logic [3:0] alarm_time_ms_hr;
  logic [3:0] alarm_time_ls_hr;
  logic [3:0] alarm_time_ms_min;
  logic [3:0] alarm_time_ls_min;
  logic       alarm_armed;
  logic       snooze_button;
  logic       stop_button;
  logic       load_new_a;
  logic       load_new_c;
  logic       alarm_sound;
  logic       snooze_active;
  logic [1:0] snoozes_left;

  modport master (
    output one_second, one_minute,
    output current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    output alarm_armed, snooze_button, stop_button, load_new_a, load_new_c,
    input  alarm_sound, snooze_active, snoozes_left
  );

  modport slave (
    input  one_second, one_minute,
    input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    input  alarm_armed, snooze_button, stop_button, load_new_a, load_new_c,
    output alarm_sound, snooze_active, snoozes_left
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: rings on a rising time/alarm match, supports a bounded
// number of snoozes, stop, disarm, and auto-timeout after RING_TIMEOUT_SEC seconds.
module alarm_ring_ctrl #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic                clock,
  input  logic                reset,
  alarm_ring_ctrl_if.slave    bus
);
  localparam logic [1:0] MAX_SN    = 2'(MAX_SNOOZES);
  localparam logic [3:0] SN_MIN    = 4'(SNOOZE_MIN);
  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_SEC - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

  state_t     state_reg;
  logic       match_q;
  logic       match_prev;
  logic       primed_reg;
  logic [7:0] sec_cnt;
  logic [3:0] min_cnt;
  logic [1:0] snooze_cnt;
  logic       alarm_sound_reg;
  logic       snooze_active_reg;
  logic [1:0] snoozes_left_reg;

  logic match_now;
  logic trigger;
  logic load;

  assign match_now = (bus.current_time_ms_hr  == bus.alarm_time_ms_hr)  &&
                     (bus.current_time_ls_hr  == bus.alarm_time_ls_hr)  &&
                     (bus.current_time_ms_min == bus.alarm_time_ms_min) &&
                     (bus.current_time_ls_min == bus.alarm_time_ls_min);
  assign trigger   = match_q & ~match_prev & bus.alarm_armed;
  assign load      = bus.load_new_a | bus.load_new_c;

  assign bus.alarm_sound   = alarm_sound_reg;
  assign bus.snooze_active = snooze_active_reg;
  assign bus.snoozes_left  = snoozes_left_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      match_q           <= 1'b0;
      match_prev        <= 1'b1;
      primed_reg        <= 1'b0;
      sec_cnt           <= '0;
      min_cnt           <= '0;
      snooze_cnt        <= '0;
      alarm_sound_reg   <= 1'b0;
      snooze_active_reg <= 1'b0;
      snoozes_left_reg  <= MAX_SN;
    end else begin
      match_q    <= match_now;
      // The first cycle out of reset holds match_prev high so a match that was
      // already present across reset does not look like a fresh rising edge.
      match_prev <= match_q | ~primed_reg;
      primed_reg <= 1'b1;

      if (load) begin
        state_reg         <= IDLE;
        match_prev        <= 1'b1;
        sec_cnt           <= '0;
        min_cnt           <= '0;
        snooze_cnt        <= '0;
        alarm_sound_reg   <= 1'b0;
        snooze_active_reg <= 1'b0;
        snoozes_left_reg  <= MAX_SN;
      end else if (!bus.alarm_armed && state_reg != IDLE) begin
        state_reg         <= IDLE;
        sec_cnt           <= '0;
        min_cnt           <= '0;
        snooze_cnt        <= '0;
        alarm_sound_reg   <= 1'b0;
        snooze_active_reg <= 1'b0;
        snoozes_left_reg  <= MAX_SN;
      end else begin
        case (state_reg)
          IDLE: begin
            if (trigger) begin
              state_reg       <= RING;
              sec_cnt         <= '0;
              alarm_sound_reg <= 1'b1;
            end
          end
          RING: begin
            if (bus.stop_button) begin
              state_reg        <= DONE;
              snooze_cnt       <= '0;
              alarm_sound_reg  <= 1'b0;
              snoozes_left_reg <= MAX_SN;
            end else if (bus.snooze_button && snooze_cnt < MAX_SN) begin
              // A simultaneous one_second tick is intentionally dropped here.
              state_reg         <= SNOOZE;
              min_cnt           <= SN_MIN;
              snooze_cnt        <= snooze_cnt + 2'd1;
              alarm_sound_reg   <= 1'b0;
              snooze_active_reg <= 1'b1;
              snoozes_left_reg  <= MAX_SN - snooze_cnt - 2'd1;
            end else if (bus.one_second) begin
              if (sec_cnt == RING_LAST) begin
                state_reg        <= DONE;
                snooze_cnt       <= '0;
                alarm_sound_reg  <= 1'b0;
                snoozes_left_reg <= MAX_SN;
              end else begin
                sec_cnt <= sec_cnt + 8'd1;
              end
            end
          end
          SNOOZE: begin
            if (bus.stop_button) begin
              state_reg         <= DONE;
              snooze_cnt        <= '0;
              snooze_active_reg <= 1'b0;
              snoozes_left_reg  <= MAX_SN;
            end else if (bus.one_minute) begin
              if (min_cnt == 4'd1) begin
                state_reg         <= RING;
                sec_cnt           <= '0;
                alarm_sound_reg   <= 1'b1;
                snooze_active_reg <= 1'b0;
              end else begin
                min_cnt <= min_cnt - 4'd1;
              end
            end
          end
          DONE: begin
            // Stay here while the minute still matches so it cannot retrigger.
            snooze_cnt       <= '0;
            snoozes_left_reg <= MAX_SN;
            if (!match_q) state_reg <= IDLE;
          end
          default: begin
            state_reg         <= IDLE;
            alarm_sound_reg   <= 1'b0;
            snooze_active_reg <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed self-checking bench for alarm_ring_ctrl: ring latency, timeout,
// snooze limits, stop priority, load blocking, disarm and reset behaviour.
module tb_alarm_ring_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic exp_sound, input logic exp_snz,
                       input logic [1:0] exp_left);
    logic [3:0] obs;
    logic [3:0] expv;
    obs  = {bus.alarm_sound, bus.snooze_active, bus.snoozes_left};
    expv = {exp_sound, exp_snz, exp_left};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed sound/snooze/left=%b expected %b", tag, obs, expv);
    end
    $display("check %-22s sound=%0b snooze=%0b left=%0d", tag,
             bus.alarm_sound, bus.snooze_active, bus.snoozes_left);
  endtask

  task automatic set_time(input logic [3:0] h1, h0, m1, m0);
    bus.current_time_ms_hr  = h1;
    bus.current_time_ls_hr  = h0;
    bus.current_time_ms_min = m1;
    bus.current_time_ls_min = m0;
  endtask

  task automatic set_alarm(input logic [3:0] h1, h0, m1, m0);
    bus.alarm_time_ms_hr  = h1;
    bus.alarm_time_ls_hr  = h0;
    bus.alarm_time_ms_min = m1;
    bus.alarm_time_ls_min = m0;
  endtask

  task automatic seconds(input int n);
    for (int i = 0; i < n; i++) begin
      bus.one_second = 1'b1;
      tick();
      bus.one_second = 1'b0;
    end
  endtask

  task automatic minutes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.one_minute = 1'b1;
      tick();
      bus.one_minute = 1'b0;
    end
  endtask

  task automatic press_snooze();
    bus.snooze_button = 1'b1;
    tick();
    bus.snooze_button = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop_button = 1'b1;
    tick();
    bus.stop_button = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.one_second    = 1'b0;
    bus.one_minute    = 1'b0;
    bus.alarm_armed   = 1'b1;
    bus.snooze_button = 1'b0;
    bus.stop_button   = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    set_alarm(4'd0, 4'd7, 4'd3, 4'd0);
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    ticks(2);
    check("reset_state", 1'b0, 1'b0, 2'd3);
    reset = 1'b0;
    ticks(2);
    check("idle_after_reset", 1'b0, 1'b0, 2'd3);

    // 1: match at edge N+1 -> ring at N+2
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    check("t1_edge1_silent", 1'b0, 1'b0, 2'd3);
    tick();
    check("t1_ring", 1'b1, 1'b0, 2'd3);

    // 2: auto-timeout after 60 seconds, DONE holds within the minute
    seconds(59);
    check("t2_59s_ringing", 1'b1, 1'b0, 2'd3);
    seconds(1);
    check("t2_timeout", 1'b0, 1'b0, 2'd3);
    ticks(5);
    check("t2_no_retrigger", 1'b0, 1'b0, 2'd3);
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    ticks(2);
    check("t2_idle_0731", 1'b0, 1'b0, 2'd3);

    // 3: snooze cycles up to the limit
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    tick();
    check("t3_edge1_silent", 1'b0, 1'b0, 2'd3);
    tick();
    check("t3_ring", 1'b1, 1'b0, 2'd3);
    bus.one_second = 1'b1;
    press_snooze();
    bus.one_second = 1'b0;
    check("t3_snooze1", 1'b0, 1'b1, 2'd2);
    minutes(2);
    press_snooze();
    check("t3_snooze_ignored", 1'b0, 1'b1, 2'd2);
    minutes(2);
    check("t3_4min_snoozing", 1'b0, 1'b1, 2'd2);
    minutes(1);
    check("t3_rering1", 1'b1, 1'b0, 2'd2);
    press_snooze();
    check("t3_snooze2", 1'b0, 1'b1, 2'd1);
    minutes(4);
    check("t3_snooze2_4min", 1'b0, 1'b1, 2'd1);
    minutes(1);
    check("t3_rering2", 1'b1, 1'b0, 2'd1);
    press_snooze();
    check("t3_snooze3", 1'b0, 1'b1, 2'd0);
    minutes(5);
    check("t3_rering3", 1'b1, 1'b0, 2'd0);
    press_snooze();
    check("t3_snooze4_ignored", 1'b1, 1'b0, 2'd0);
    press_stop();
    check("t3_stop", 1'b0, 1'b0, 2'd3);

    // 4: stop and snooze together -> stop wins
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    ticks(2);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    ticks(2);
    check("t4_ring", 1'b1, 1'b0, 2'd3);
    press_snooze();
    check("t4_snooze", 1'b0, 1'b1, 2'd2);
    minutes(5);
    check("t4_rering", 1'b1, 1'b0, 2'd2);
    bus.stop_button   = 1'b1;
    bus.snooze_button = 1'b1;
    tick();
    bus.stop_button   = 1'b0;
    bus.snooze_button = 1'b0;
    check("t4_stop_wins", 1'b0, 1'b0, 2'd3);

    // 5: loads suppress the trigger until the match falls and rises again
    bus.load_new_a = 1'b1;
    set_alarm(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    bus.load_new_c = 1'b1;
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    bus.load_new_a = 1'b0;
    bus.load_new_c = 1'b0;
    ticks(4);
    check("t5_load_no_ring", 1'b0, 1'b0, 2'd3);
    bus.load_new_c = 1'b1;
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    tick();
    bus.load_new_c = 1'b0;
    ticks(3);
    bus.load_new_c = 1'b1;
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    ticks(2);
    bus.load_new_c = 1'b0;
    ticks(4);
    check("t5_reload_no_ring", 1'b0, 1'b0, 2'd3);
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    ticks(2);
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    check("t5_rise_edge1", 1'b0, 1'b0, 2'd3);
    tick();
    check("t5_rise_ring", 1'b1, 1'b0, 2'd3);
    bus.load_new_a = 1'b1;
    tick();
    check("t5_load_while_ring", 1'b0, 1'b0, 2'd3);
    bus.load_new_a = 1'b0;
    ticks(3);
    check("t5_after_load_quiet", 1'b0, 1'b0, 2'd3);

    // 6: disarm during snooze, disarmed match, reset during ring
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    ticks(2);
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    ticks(2);
    check("t6_ring", 1'b1, 1'b0, 2'd3);
    press_snooze();
    check("t6_snooze", 1'b0, 1'b1, 2'd2);
    bus.alarm_armed = 1'b0;
    tick();
    check("t6_disarm_idle", 1'b0, 1'b0, 2'd3);
    bus.alarm_armed = 1'b1;
    ticks(3);
    check("t6_rearm_quiet", 1'b0, 1'b0, 2'd3);
    bus.alarm_armed = 1'b0;
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    ticks(2);
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    ticks(3);
    check("t6_disarmed_match", 1'b0, 1'b0, 2'd3);
    bus.alarm_armed = 1'b1;
    ticks(2);
    check("t6_arm_late_quiet", 1'b0, 1'b0, 2'd3);
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    ticks(2);
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    ticks(2);
    check("t6_ring_again", 1'b1, 1'b0, 2'd3);
    reset = 1'b1;
    tick();
    check("t6_reset_in_ring", 1'b0, 1'b0, 2'd3);
    reset = 1'b0;
    ticks(4);
    check("t6_no_retrigger", 1'b0, 1'b0, 2'd3);
    set_time(4'd1, 4'd2, 4'd0, 4'd1);
    ticks(2);
    set_time(4'd1, 4'd2, 4'd0, 4'd0);
    tick();
    check("t6_rise_edge1", 1'b0, 1'b0, 2'd3);
    tick();
    check("t6_rise_ring", 1'b1, 1'b0, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
